seg7_readback_monitor: RTL and testbench

//  Receiving end of the stopwatch display bus. Samples the four 7-segment buses disp1..disp4 and filters them for stability.

---
 rtl/seg7_readback_monitor_pkg.sv | 60 ++++++
 rtl/seg7_to_bcd.sv | 30 +++
 rtl/seg7_readback_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_seg7_readback_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_readback_monitor_pkg.sv
// Shared constants and helpers for the 7-segment readback monitor.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg7_readback_monitor_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BAD   = 4'hF;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_TRACK  = 1'b1;

    typedef struct packed {
        logic step;
        logic zero;
        logic skip;
    } step_class_t;

    // Binary to four packed BCD digits; used to turn WRAP_MAX into a BCD constant.
    function automatic logic [15:0] to_bcd16(input int unsigned v);
        logic [15:0] r;
        r = {4'((v / 32'd1000) % 32'd10),
             4'((v / 32'd100)  % 32'd10),
             4'((v / 32'd10)   % 32'd10),
             4'(v % 32'd10)};
        return r;
    endfunction

    // Four-digit BCD increment with per-digit carry; 9999 rolls over to 0000.
    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low 7-segment pattern back to a BCD digit.
// Patterns outside 0..9 (including blank) return BCD_BAD and raise illegal.
module seg7_to_bcd
    import seg7_readback_monitor_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       illegal
);

    // Pattern lookup; anything not a decimal glyph is flagged.
    always_comb begin
        digit   = BCD_BAD;
        illegal = 1'b1;
        case (seg)
            SEG_0:   begin digit = 4'd0; illegal = 1'b0; end
            SEG_1:   begin digit = 4'd1; illegal = 1'b0; end
            SEG_2:   begin digit = 4'd2; illegal = 1'b0; end
            SEG_3:   begin digit = 4'd3; illegal = 1'b0; end
            SEG_4:   begin digit = 4'd4; illegal = 1'b0; end
            SEG_5:   begin digit = 4'd5; illegal = 1'b0; end
            SEG_6:   begin digit = 4'd6; illegal = 1'b0; end
            SEG_7:   begin digit = 4'd7; illegal = 1'b0; end
            SEG_8:   begin digit = 4'd8; illegal = 1'b0; end
            SEG_9:   begin digit = 4'd9; illegal = 1'b0; end
            default: begin digit = BCD_BAD; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_readback_monitor.sv
// Stability-filtered readback of a 4-digit 7-segment display with legal-advance checking.
// Optional hold detector enabled by defining SEG7_FREEZE_DET_EN.
module seg7_readback_monitor
    import seg7_readback_monitor_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned WRAP_MAX      = 9999,
    parameter int unsigned FREEZE_CYCLES = 1000
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic [6:0]  disp1,
    input  logic [6:0]  disp2,
    input  logic [6:0]  disp3,
    input  logic [6:0]  disp4,
    input  logic        err_clr,
    output logic [15:0] bcd,
    output logic        val_valid,
    output logic        step_ok,
    output logic        zero_seen,
    output logic        skip_err,
    output logic        seg_err,
    output logic        err_sticky,
    output logic        frozen
);

    localparam int unsigned CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
    localparam logic [15:0]   WRAP_BCD   = to_bcd16(WRAP_MAX);

    if (STABLE_CYCLES < 1 || FREEZE_CYCLES < 1) begin : g_bad_cfg
        $error("seg7_readback_monitor: STABLE_CYCLES and FREEZE_CYCLES must be >= 1");
    end

    logic [27:0]   in_s;
    logic [27:0]   samp_r;
    logic [27:0]   last_r;
    logic          have_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          accept_s;

    logic [3:0]    dig_s [4];
    logic [3:0]    bad_s;
    logic [15:0]   val_s;
    logic          any_bad_s;

    logic [0:0]    state_r;
    logic [0:0]    state_next_s;
    logic [15:0]   prev_r;
    logic [15:0]   prev_next_s;
    logic [15:0]   incr_s;
    step_class_t   cls_s;
    logic          seg_err_s;
    logic          err_next_s;

    logic [15:0]   bcd_r;
    logic          val_valid_r;
    logic          step_ok_r;
    logic          zero_seen_r;
    logic          skip_err_r;
    logic          seg_err_r;
    logic          err_sticky_r;

    assign in_s = {disp4, disp3, disp2, disp1};

    // Decode the stable sample, not the raw input, so bcd matches what was filtered.
    for (genvar g = 0; g < 4; g++) begin : g_dec
        seg7_to_bcd u_dec (
            .seg     (samp_r[7*g +: 7]),
            .digit   (dig_s[g]),
            .illegal (bad_s[g])
        );
    end

    assign val_s     = {dig_s[3], dig_s[2], dig_s[1], dig_s[0]};
    assign any_bad_s = |bad_s;

    // Stability counter: restart on any input change, saturate once stable.
    always_comb begin
        cnt_next_s = cnt_r;
        if (in_s != samp_r) begin
            cnt_next_s = '0;
        end else if (cnt_r != STABLE_MAX) begin
            cnt_next_s = cnt_r + CW'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // A non-zero next count implies the input already equals samp_r.
    assign accept_s = (cnt_next_s == STABLE_MAX) && (!have_r || (samp_r != last_r));

    assign incr_s = (prev_r == WRAP_BCD) ? 16'h0000 : bcd_inc16(prev_r);

    // Advance classification and FSM; illegal patterns never touch the reference value.
    always_comb begin
        cls_s        = '0;
        state_next_s = state_r;
        prev_next_s  = prev_r;
        if (accept_s && !any_bad_s) begin
            prev_next_s = val_s;
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_TRACK;
                end
                ST_TRACK: begin
                    state_next_s = ST_TRACK;
                    if (val_s == incr_s) begin
                        cls_s.step = 1'b1;
                    end else if (val_s == 16'h0000) begin
                        cls_s.zero = 1'b1;
                    end else begin
                        cls_s.skip = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    assign seg_err_s = accept_s && any_bad_s;

    // A new error outranks a simultaneous clear request.
    always_comb begin
        err_next_s = err_sticky_r;
        if (seg_err_s || cls_s.skip) begin
            err_next_s = 1'b1;
        end else if (err_clr) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = err_sticky_r;
        end
    end

    // Sampler, acceptance bookkeeping and registered outputs.
    always_ff @(posedge clkin) begin
        if (!reset) begin
            samp_r       <= '0;
            last_r       <= '0;
            have_r       <= 1'b0;
            cnt_r        <= '0;
            state_r      <= ST_IDLE;
            prev_r       <= 16'h0000;
            bcd_r        <= 16'h0000;
            val_valid_r  <= 1'b0;
            step_ok_r    <= 1'b0;
            zero_seen_r  <= 1'b0;
            skip_err_r   <= 1'b0;
            seg_err_r    <= 1'b0;
            err_sticky_r <= 1'b0;
        end else begin
            samp_r       <= in_s;
            cnt_r        <= cnt_next_s;
            state_r      <= state_next_s;
            prev_r       <= prev_next_s;
            val_valid_r  <= accept_s;
            step_ok_r    <= cls_s.step;
            zero_seen_r  <= cls_s.zero;
            skip_err_r   <= cls_s.skip;
            seg_err_r    <= seg_err_s;
            err_sticky_r <= err_next_s;
            if (accept_s) begin
                last_r <= samp_r;
                have_r <= 1'b1;
                bcd_r  <= val_s;
            end else begin
                last_r <= last_r;
                have_r <= have_r;
                bcd_r  <= bcd_r;
            end
        end
    end

    assign bcd        = bcd_r;
    assign val_valid  = val_valid_r;
    assign step_ok    = step_ok_r;
    assign zero_seen  = zero_seen_r;
    assign skip_err   = skip_err_r;
    assign seg_err    = seg_err_r;
    assign err_sticky = err_sticky_r;

`ifdef SEG7_FREEZE_DET_EN
    localparam int unsigned IW       = $clog2(FREEZE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(FREEZE_CYCLES);

    logic [IW-1:0] idle_cnt_r;
    logic [IW-1:0] idle_next_s;
    logic          frozen_r;

    // Cycles since the last accepted change, saturating at the freeze threshold.
    always_comb begin
        idle_next_s = idle_cnt_r;
        if (val_valid_r) begin
            idle_next_s = '0;
        end else if (idle_cnt_r != IDLE_MAX) begin
            idle_next_s = idle_cnt_r + IW'(1);
        end else begin
            idle_next_s = idle_cnt_r;
        end
    end

    // Registered freeze flag; drops the cycle after the next acceptance.
    always_ff @(posedge clkin) begin
        if (!reset) begin
            idle_cnt_r <= '0;
            frozen_r   <= 1'b0;
        end else begin
            idle_cnt_r <= idle_next_s;
            frozen_r   <= (idle_next_s == IDLE_MAX);
        end
    end

    assign frozen = frozen_r;
`else
    assign frozen = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_readback_monitor.sv
// Directed self-checking bench for seg7_readback_monitor (STABLE_CYCLES=2, FREEZE_CYCLES=20).
// Freeze scenario is compiled in when SEG7_FREEZE_DET_EN is defined.
module tb_seg7_readback_monitor;

    logic        clkin = 1'b0;
    logic        reset;
    logic [6:0]  disp1, disp2, disp3, disp4;
    logic        err_clr;
    logic [15:0] bcd;
    logic        val_valid, step_ok, zero_seen, skip_err, seg_err, err_sticky, frozen;

    int checks = 0;
    int errors = 0;

    int n_vv, n_step, n_zero, n_skip, n_seg;
    logic sticky_at_vv, frozen_at_vv, frozen_after_vv, frozen_any, prev_vv;

    seg7_readback_monitor #(
        .STABLE_CYCLES (2),
        .WRAP_MAX      (9999),
        .FREEZE_CYCLES (20)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .disp1      (disp1),
        .disp2      (disp2),
        .disp3      (disp3),
        .disp4      (disp4),
        .err_clr    (err_clr),
        .bcd        (bcd),
        .val_valid  (val_valid),
        .step_ok    (step_ok),
        .zero_seen  (zero_seen),
        .skip_err   (skip_err),
        .seg_err    (seg_err),
        .err_sticky (err_sticky),
        .frozen     (frozen)
    );

    always #5 clkin = ~clkin;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] enc(input logic [15:0] v);
        return {seg_of(v[15:12]), seg_of(v[11:8]), seg_of(v[7:4]), seg_of(v[3:0])};
    endfunction

    // Drive a raw 28-bit pattern for n cycles and tally the output pulses seen.
    task automatic hold_raw(input logic [27:0] p, input int n);
        {disp4, disp3, disp2, disp1} = p;
        n_vv = 0; n_step = 0; n_zero = 0; n_skip = 0; n_seg = 0;
        sticky_at_vv = 1'b0; frozen_at_vv = 1'b0; frozen_after_vv = 1'b0;
        frozen_any = 1'b0; prev_vv = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clkin); #1;
            if (prev_vv) frozen_after_vv = frozen;
            if (val_valid) begin
                sticky_at_vv = err_sticky;
                frozen_at_vv = frozen;
            end
            n_vv   += int'(val_valid);
            n_step += int'(step_ok);
            n_zero += int'(zero_seen);
            n_skip += int'(skip_err);
            n_seg  += int'(seg_err);
            frozen_any |= frozen;
            prev_vv = val_valid;
        end
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        hold_raw(enc(v), n);
    endtask

    task automatic clr_pulse;
        err_clr = 1'b1;
        @(posedge clkin); #1;
        err_clr = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; err_clr = 1'b0;
        {disp4, disp3, disp2, disp1} = enc(16'h0000);
        repeat (2) @(posedge clkin);
        #1;
        checks++; if (bcd !== 16'h0000 || val_valid !== 1'b0 || err_sticky !== 1'b0 || frozen !== 1'b0) begin
            errors++; $display("FAIL reset_state bcd=%h vv=%b sticky=%b frozen=%b expected 0000/0/0/0", bcd, val_valid, err_sticky, frozen);
        end
        reset = 1'b1;
        hold(16'h0000, 5);
        checks++; if (n_vv !== 1 || n_step !== 0 || n_skip !== 0 || n_zero !== 0) begin
            errors++; $display("FAIL first_accept vv=%0d step=%0d skip=%0d zero=%0d expected 1/0/0/0", n_vv, n_step, n_skip, n_zero);
        end
        checks++; if (bcd !== 16'h0000 || err_sticky !== 1'b0) begin
            errors++; $display("FAIL first_value bcd=%h sticky=%b expected 0000/0", bcd, err_sticky);
        end
    endtask

    task automatic test_count;
        int steps = 0, skips = 0, vvs = 0;
        for (int i = 1; i <= 12; i++) begin
            hold({4'd0, 4'd0, 4'(i / 10), 4'(i % 10)}, 5);
            steps += n_step; skips += n_skip; vvs += n_vv;
        end
        checks++; if (steps !== 12 || skips !== 0 || vvs !== 12) begin
            errors++; $display("FAIL count_steps step=%0d skip=%0d vv=%0d expected 12/0/12", steps, skips, vvs);
        end
        checks++; if (bcd !== 16'h0012) begin
            errors++; $display("FAIL count_value bcd=%h expected 0012", bcd);
        end
    endtask

    task automatic test_glitch;
        logic [27:0] p;
        int vvs;
        p = enc(16'h0012);
        p[6:0] = 7'h79;
        hold_raw(p, 1);
        vvs = n_vv;
        hold(16'h0012, 5);
        vvs += n_vv;
        checks++; if (vvs !== 0 || bcd !== 16'h0012) begin
            errors++; $display("FAIL glitch vv=%0d bcd=%h expected 0/0012", vvs, bcd);
        end
    endtask

    task automatic test_wrap;
        hold(16'h9999, 5);
        checks++; if (n_skip !== 1 || err_sticky !== 1'b1) begin
            errors++; $display("FAIL jump_to_9999 skip=%0d sticky=%b expected 1/1", n_skip, err_sticky);
        end
        clr_pulse();
        hold(16'h0000, 5);
        checks++; if (n_step !== 1 || n_zero !== 0 || n_skip !== 0 || bcd !== 16'h0000) begin
            errors++; $display("FAIL wrap step=%0d zero=%0d skip=%0d bcd=%h expected 1/0/0/0000", n_step, n_zero, n_skip, bcd);
        end
        hold(16'h0005, 5);
        checks++; if (n_skip !== 1 || err_sticky !== 1'b1) begin
            errors++; $display("FAIL skip_0005 skip=%0d sticky=%b expected 1/1", n_skip, err_sticky);
        end
        clr_pulse();
        checks++; if (err_sticky !== 1'b0) begin
            errors++; $display("FAIL err_clr sticky=%b expected 0", err_sticky);
        end
    endtask

    task automatic test_blank;
        logic [27:0] p;
        p = enc(16'h0005);
        p[20:14] = 7'h7F;
        hold_raw(p, 3);
        checks++; if (n_seg !== 1 || n_step !== 0 || n_skip !== 0 || n_zero !== 0) begin
            errors++; $display("FAIL blank_pulses seg=%0d step=%0d skip=%0d zero=%0d expected 1/0/0/0", n_seg, n_step, n_skip, n_zero);
        end
        checks++; if (bcd !== 16'h0F05 || err_sticky !== 1'b1) begin
            errors++; $display("FAIL blank_value bcd=%h sticky=%b expected 0F05/1", bcd, err_sticky);
        end
        hold(16'h0006, 5);
        checks++; if (n_step !== 1 || n_skip !== 0 || bcd !== 16'h0006) begin
            errors++; $display("FAIL after_blank step=%0d skip=%0d bcd=%h expected 1/0/0006", n_step, n_skip, bcd);
        end
    endtask

    task automatic test_simultaneous;
        err_clr = 1'b1;
        hold(16'h0009, 5);
        err_clr = 1'b0;
        checks++; if (n_skip !== 1 || sticky_at_vv !== 1'b1) begin
            errors++; $display("FAIL err_vs_clr skip=%0d sticky_at_vv=%b expected 1/1", n_skip, sticky_at_vv);
        end
        checks++; if (err_sticky !== 1'b0) begin
            errors++; $display("FAIL clr_after_err sticky=%b expected 0", err_sticky);
        end
    endtask

    task automatic test_freeze;
`ifdef SEG7_FREEZE_DET_EN
        hold(16'h0042, 25);
        checks++; if (frozen !== 1'b1) begin
            errors++; $display("FAIL freeze_set frozen=%b expected 1", frozen);
        end
        hold(16'h0043, 5);
        checks++; if (n_vv !== 1 || frozen_at_vv !== 1'b1 || frozen_after_vv !== 1'b0) begin
            errors++; $display("FAIL freeze_clear vv=%0d at_vv=%b after=%b expected 1/1/0", n_vv, frozen_at_vv, frozen_after_vv);
        end
`else
        hold(16'h0042, 25);
        checks++; if (frozen_any !== 1'b0 || n_vv !== 1) begin
            errors++; $display("FAIL freeze_disabled frozen_seen=%b vv=%0d expected 0/1", frozen_any, n_vv);
        end
`endif
    endtask

    task automatic test_reset_mid;
        reset = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        checks++; if (bcd !== 16'h0000 || err_sticky !== 1'b0 || val_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset bcd=%h sticky=%b vv=%b expected 0000/0/0", bcd, err_sticky, val_valid);
        end
        reset = 1'b1;
        hold(16'h0009, 5);
        checks++; if (n_vv !== 1 || n_step !== 0 || n_skip !== 0 || n_zero !== 0 || bcd !== 16'h0009) begin
            errors++; $display("FAIL reaccept_after_reset vv=%0d step=%0d skip=%0d zero=%0d bcd=%h expected 1/0/0/0/0009",
                               n_vv, n_step, n_skip, n_zero, bcd);
        end
        hold(16'h0010, 5);
        checks++; if (n_step !== 1 || n_skip !== 0 || bcd !== 16'h0010) begin
            errors++; $display("FAIL carry_step step=%0d skip=%0d bcd=%h expected 1/0/0010", n_step, n_skip, bcd);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_glitch();
        test_wrap();
        test_blank();
        test_simultaneous();
        test_freeze();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
